spike_rate_decoder: RTL and testbench

Receiving end of the neuron spike interface. Converts a 1-bit spike train, such as the output of a LIF neuron, back into a multi-bit rate value by counting spikes over a programmable window of clock cycles. Each completed window count is presented on a single-entry valid/ready output register. The block sits downstream of neuron outputs, feeding readout logic or the next layer's current input.

---
 rtl/spike_rate_decoder_pkg.sv | 17 +
 rtl/spike_rate_decoder_if.sv | 10 +
 rtl/spike_rate_decoder_sat_up_counter.sv | 31 +++
 rtl/spike_rate_decoder.sv | 148 ++++++++++++++
 tb/tb_spike_rate_decoder.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/spike_rate_decoder_pkg.sv
// Shared types and defaults for the spike rate decoder slice.
package spike_pkg;

  localparam int WINDOW_W_DEF = 8;
  localparam int COUNT_W_DEF  = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  // All-ones value of a w-bit saturating counter (w up to 32).
  function automatic logic [31:0] sat_max(input int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/spike_rate_decoder_if.sv
// Result handshake bus: rate value plus valid/ready and the saturation flag.
interface spike_rate_decoder_if #(parameter int COUNT_W = 8);
  logic [COUNT_W-1:0] rate_out;
  logic               rate_valid;
  logic               rate_ready;
  logic               rate_sat;

  modport master (output rate_out, rate_valid, rate_sat, input rate_ready);
  modport slave  (input rate_out, rate_valid, rate_sat, output rate_ready);
endinterface

// File: rtl/spike_rate_decoder_sat_up_counter.sv
// Saturating up-counter with sticky overflow-attempt flag; clr wins over inc.
module sat_up_counter
  import spike_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         sat
);

  localparam logic [W-1:0] MAX = W'(sat_max(W));

  // Count up, holding at MAX and flagging any increment attempted there.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (inc) begin
      if (cnt == MAX) sat <= 1'b1;
      else            cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/spike_rate_decoder.sv
// Spike-train to rate decoder: counts spikes over back-to-back windows of
// window_len cycles and presents each count on a single-entry valid/ready
// register. Optional feature macro SPIKE_ISI_EN adds isi_out, the length in
// COUNT cycles of the most recent inter-spike interval.
module spike_rate_decoder
  import spike_pkg::*;
#(
  parameter int WINDOW_W = WINDOW_W_DEF,
  parameter int COUNT_W  = COUNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  spike_in,
  input  logic [WINDOW_W-1:0]   window_len,
  spike_rate_decoder_if.master  rate,
  output logic                  overrun,
  output logic                  busy
`ifdef SPIKE_ISI_EN
  ,
  output logic [COUNT_W-1:0]    isi_out
`endif
);

  localparam logic [COUNT_W-1:0] CMAX = COUNT_W'(sat_max(COUNT_W));

  state_t              state_q, state_d;
  logic [WINDOW_W-1:0] remaining;
  logic [WINDOW_W-1:0] win_len_eff;
  logic                load_win;
  logic                inc_cnt;
  logic                land;

  logic [COUNT_W-1:0]  spike_cnt;
  logic                spike_sat;
  logic [COUNT_W-1:0]  cnt_incl;
  logic                sat_incl;

  // A zero-length window behaves as a one-cycle window.
  assign win_len_eff = (window_len == '0) ? WINDOW_W'(1) : window_len;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and per-cycle window controls.
  always_comb begin
    state_d  = state_q;
    load_win = 1'b0;
    inc_cnt  = 1'b0;
    land     = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          load_win = 1'b1;
          state_d  = COUNT;
        end
      end
      COUNT: begin
        if (!enable) begin
          state_d = IDLE;
        end else begin
          inc_cnt = spike_in;
          if (remaining <= WINDOW_W'(1)) begin
            land     = 1'b1;
            load_win = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Window down-counter: reloaded at every window start, including back-to-back.
  always_ff @(posedge clk) begin
    if (!rst_n)                                remaining <= '0;
    else if (load_win)                         remaining <= win_len_eff;
    else if (state_q == COUNT && enable)       remaining <= remaining - WINDOW_W'(1);
  end

  sat_up_counter #(.W(COUNT_W)) u_spike_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (load_win),
    .inc   (inc_cnt),
    .cnt   (spike_cnt),
    .sat   (spike_sat)
  );

  // The terminal cycle's own spike is folded in here, since the counter clears.
  assign cnt_incl = (inc_cnt && spike_cnt != CMAX) ? spike_cnt + COUNT_W'(1) : spike_cnt;
  assign sat_incl = spike_sat | (inc_cnt && spike_cnt == CMAX);

  // Result register: a new result always wins; dropping an unread one is sticky.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rate.rate_out   <= '0;
      rate.rate_valid <= 1'b0;
      rate.rate_sat   <= 1'b0;
      overrun         <= 1'b0;
    end else if (land) begin
      rate.rate_out   <= cnt_incl;
      rate.rate_sat   <= sat_incl;
      rate.rate_valid <= 1'b1;
      if (rate.rate_valid && !rate.rate_ready) overrun <= 1'b1;
    end else if (rate.rate_valid && rate.rate_ready) begin
      rate.rate_valid <= 1'b0;
    end
  end

  // busy mirrors the registered state.
  always_ff @(posedge clk) begin
    if (!rst_n) busy <= 1'b0;
    else        busy <= (state_d == COUNT);
  end

`ifdef SPIKE_ISI_EN
  logic [COUNT_W-1:0] isi_cnt;
  logic               isi_sat;
  logic [COUNT_W-1:0] isi_incl;
  logic               isi_run;
  logic               isi_clr;

  // The counter holds cycles since the last spike excluding the current one,
  // so the reported interval includes the spike cycle itself.
  assign isi_run  = (state_q == COUNT) && enable;
  assign isi_clr  = (state_q == IDLE && enable) || (isi_run && spike_in);
  assign isi_incl = (isi_sat || isi_cnt == CMAX) ? isi_cnt : isi_cnt + COUNT_W'(1);

  sat_up_counter #(.W(COUNT_W)) u_isi_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (isi_clr),
    .inc   (isi_run),
    .cnt   (isi_cnt),
    .sat   (isi_sat)
  );

  // Capture the interval on every counted spike.
  always_ff @(posedge clk) begin
    if (!rst_n)                   isi_out <= '0;
    else if (isi_run && spike_in) isi_out <= isi_incl;
  end
`endif

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Self-checking bench for spike_rate_decoder: table-driven windows with a
// result scoreboard, plus hand sequences for latency, abort, overrun, reset,
// saturation (4-bit instance) and, when SPIKE_ISI_EN is defined, isi_out.
module tb_spike_rate_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable, spike_in;
  logic [7:0] window_len;
  logic       overrun, busy;
`ifdef SPIKE_ISI_EN
  logic [7:0] isi_out;
`endif

  logic       en4, spk4;
  logic [7:0] wl4;
  logic       overrun4, busy4;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {int rate; int sat;} exp_t;
  typedef struct {int wlen; int period; int nwin; int rate; int sat;} row_t;
  exp_t sb[$];
  row_t rows[7];

  spike_rate_decoder_if #(.COUNT_W(8)) rif();
  spike_rate_decoder_if #(.COUNT_W(4)) if4();

  always #5 clk = ~clk;

  spike_rate_decoder #(.WINDOW_W(8), .COUNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .spike_in   (spike_in),
    .window_len (window_len),
    .rate       (rif),
    .overrun    (overrun),
    .busy       (busy)
`ifdef SPIKE_ISI_EN
    ,
    .isi_out    (isi_out)
`endif
  );

  spike_rate_decoder #(.WINDOW_W(8), .COUNT_W(4)) dut4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (en4),
    .spike_in   (spk4),
    .window_len (wl4),
    .rate       (if4),
    .overrun    (overrun4),
    .busy       (busy4)
`ifdef SPIKE_ISI_EN
    ,
    .isi_out    ()
`endif
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive spike_in, then settle just past the rising edge.
  task automatic step(input logic s);
    spike_in = s;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted result is compared with the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && rif.rate_valid && rif.rate_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_result: got rate=%0d with no expectation at %0t",
                 rif.rate_out, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_rate", int'(rif.rate_out), e.rate);
        chk("sb_sat", int'(rif.rate_sat), e.sat);
      end
    end
  end

  initial begin
    rows[0] = '{100, 4, 2, 25, 0};
    rows[1] = '{7, 2, 2, 4, 0};
    rows[2] = '{255, 1, 1, 255, 0};
    rows[3] = '{200, 3, 1, 67, 0};
    rows[4] = '{1, 1, 3, 1, 0};
    rows[5] = '{16, 5, 2, 4, 0};
    rows[6] = '{3, 2, 2, 2, 0};

    rst_n = 1'b0; enable = 1'b0; spike_in = 1'b0; window_len = 8'd0;
    rif.rate_ready = 1'b0;
    en4 = 1'b0; spk4 = 1'b0; wl4 = 8'd0; if4.rate_ready = 1'b1;
    step(0); step(0);
    chk("rst_rate_out", int'(rif.rate_out), 0);
    chk("rst_valid", int'(rif.rate_valid), 0);
    chk("rst_sat", int'(rif.rate_sat), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_busy", int'(busy), 0);
`ifdef SPIKE_ISI_EN
    chk("rst_isi", int'(isi_out), 0);
`endif
    rst_n = 1'b1;
    rif.rate_ready = 1'b1;
    step(0);

    // Continuous spikes, window 10: first result on the 11th edge counting
    // the enable-sample edge, then one single-cycle pulse every 10 cycles.
    begin
      int early = 0;
      window_len = 8'd10; enable = 1'b1;
      step(1);
      chk("t1_busy", int'(busy), 1);
      sb.push_back('{10, 0}); sb.push_back('{10, 0});
      for (int k = 1; k <= 9; k++) begin
        step(1);
        if (rif.rate_valid) early++;
      end
      chk("t1_no_early_valid", early, 0);
      step(1);
      chk("t1_valid_edge11", int'(rif.rate_valid), 1);
      chk("t1_rate", int'(rif.rate_out), 10);
      step(1);
      chk("t1_pulse_one_cycle", int'(rif.rate_valid), 0);
      for (int k = 2; k <= 10; k++) step(1);
      chk("t1_second_valid", int'(rif.rate_valid), 1);
      enable = 1'b0;
      step(0); step(0);
    end

    // Table rows: phase-aligned spike every 'period' cycles of each window.
    foreach (rows[i]) begin
      window_len = 8'(rows[i].wlen);
      enable = 1'b1;
      step(1);
      for (int w = 0; w < rows[i].nwin; w++) begin
        sb.push_back('{rows[i].rate, rows[i].sat});
        for (int c = 0; c < rows[i].wlen; c++) step((c % rows[i].period) == 0);
      end
      enable = 1'b0;
      step(0); step(0);
      chk("row_drained", sb.size(), 0);
      chk("row_overrun", int'(overrun), 0);
      chk("row_idle", int'(busy), 0);
    end

    // Abort mid-window: no result, and spikes before re-entry do not count.
    window_len = 8'd8; enable = 1'b1;
    step(0);
    step(1); step(1); step(1); step(1); step(0);
    enable = 1'b0;
    step(1);
    chk("t5_abort_idle", int'(busy), 0);
    chk("t5_abort_no_result", int'(rif.rate_valid), 0);
    enable = 1'b1;
    step(1);
    sb.push_back('{3, 0});
    step(1); step(0); step(1); step(0); step(0); step(0); step(0); step(1);
    enable = 1'b0;
    step(0); step(0);
    chk("t5_drained", sb.size(), 0);

    // Zero window length: a result every cycle equal to that cycle's spike.
    window_len = 8'd0; enable = 1'b1;
    step(0);
    begin
      logic [4:0] pat;
      pat = 5'b01101;
      for (int k = 0; k < 5; k++) begin
        sb.push_back('{int'(pat[k]), 0});
        step(pat[k]);
      end
    end
    enable = 1'b0;
    step(0);
    chk("t5_w0_drained", sb.size(), 0);
    chk("t5_w0_valid_clear", int'(rif.rate_valid), 0);

    // Overrun: two unread windows (2 then 3 spikes), then one ready cycle.
    window_len = 8'd5; rif.rate_ready = 1'b0; enable = 1'b1;
    step(0);
    step(1); step(1); step(0); step(0); step(0);
    step(1); step(0); step(1); step(0); step(1);
    chk("t4_rate", int'(rif.rate_out), 3);
    chk("t4_overrun", int'(overrun), 1);
    chk("t4_valid", int'(rif.rate_valid), 1);
    sb.push_back('{3, 0});
    enable = 1'b0; rif.rate_ready = 1'b1;
    step(0);
    rif.rate_ready = 1'b0;
    chk("t4_valid_cleared", int'(rif.rate_valid), 0);
    chk("t4_overrun_sticky", int'(overrun), 1);
    chk("t4_drained", sb.size(), 0);

    // Reset mid-window with a pending result and overrun set.
    window_len = 8'd3; enable = 1'b1;
    step(0);
    step(1); step(0); step(0);
    step(1); step(1); step(0);
    step(1);
    chk("t6_pre_valid", int'(rif.rate_valid), 1);
    chk("t6_pre_overrun", int'(overrun), 1);
    rst_n = 1'b0;
    step(1);
    chk("t6_rate_out", int'(rif.rate_out), 0);
    chk("t6_valid", int'(rif.rate_valid), 0);
    chk("t6_sat", int'(rif.rate_sat), 0);
    chk("t6_overrun", int'(overrun), 0);
    chk("t6_busy", int'(busy), 0);
    enable = 1'b0; rst_n = 1'b1; rif.rate_ready = 1'b1;
    step(0);

`ifdef SPIKE_ISI_EN
    // Spikes on COUNT cycles 3 and 10 report intervals of 3 and 7.
    window_len = 8'd50; enable = 1'b1;
    step(1);
    for (int c = 1; c <= 12; c++) begin
      step(c == 3 || c == 10);
      if (c == 3)  chk("isi_first", int'(isi_out), 3);
      if (c == 9)  chk("isi_hold", int'(isi_out), 3);
      if (c == 10) chk("isi_second", int'(isi_out), 7);
    end
    enable = 1'b0;
    step(0);
`endif

    // 4-bit instance: a 20-spike window saturates, an empty window does not.
    wl4 = 8'd20; en4 = 1'b1;
    @(posedge clk); #1;
    spk4 = 1'b1;
    for (int c = 0; c < 20; c++) begin @(posedge clk); #1; end
    chk("t3_valid", int'(if4.rate_valid), 1);
    chk("t3_rate_sat_val", int'(if4.rate_out), 15);
    chk("t3_sat", int'(if4.rate_sat), 1);
    spk4 = 1'b0;
    for (int c = 0; c < 20; c++) begin @(posedge clk); #1; end
    chk("t3_valid2", int'(if4.rate_valid), 1);
    chk("t3_rate_zero", int'(if4.rate_out), 0);
    chk("t3_sat_clear", int'(if4.rate_sat), 0);
    chk("t3_no_overrun", int'(overrun4), 0);
    en4 = 1'b0;
    step(0); step(0);

    chk("final_sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
